// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-memory stage behind the CPU datapath.
//
// This block runs a MOV/MOC handshake around a word-organised RAM array.
// The array is byte-addressed and big-endian. It supports byte, halfword
// and word accesses, sign or zero extension on loads, and programmable
// wait states.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   enable      chip enable; a request is accepted only when high
//   mov         memory operation valid from the CPU
//   rw          1 = load, 0 = store
//   size        00 byte, 01 halfword, 10/11 word
//   unsigned_ld 1 = zero-extend byte/half loads, 0 = sign-extend
//   addr        byte address
//   data_in     store data; byte/half taken from the low bits
//   data_out    registered load data
//   moc         memory operation complete
//   busy        high while an access is in flight or awaiting release
//   err         misaligned-access fault, valid while moc = 1
//
// Optional feature (macro DATA_MEM_MISALIGN_TRAP_EN):
//   When defined, a misaligned halfword or word access is a fault. It does
//   not touch the array or data_out, and it raises err for the whole
//   completion phase. When undefined, misaligned addresses are
//   force-aligned and err is tied low.
module data_mem_ctrl #(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mov,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
  output logic        busy,
  output logic        err
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_nxt;
  logic [3:0]     cnt;
  logic           accept, exec, leave, fault;

  logic           rw_l, uns_l;
  logic [1:0]     size_l;
  logic [AW+1:0]  addr_l;
  logic [31:0]    din_l;

  logic [31:0]    mem [DEPTH];
  logic [AW-1:0]  widx;
  logic [31:0]    word_rd;

  // Address bits above the array span are ignored, so addresses wrap.
  logic           unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  // Right-justify the addressed big-endian lane, then extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  lane,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = lane[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed lanes of the current word.
  function automatic logic [31:0] store_merge(input logic [31:0] w,
                                              input logic [31:0] d,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00: begin
        case (lane)
          2'd0:    r[31:24] = d[7:0];
          2'd1:    r[23:16] = d[7:0];
          2'd2:    r[15:8]  = d[7:0];
          default: r[7:0]   = d[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) r[15:0]  = d[15:0];
        else         r[31:16] = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  assign widx    = addr_l[AW+1:2];
  assign word_rd = mem[widx];
  assign busy    = (state != IDLE);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign fault = ((size_l == 2'b01) && addr_l[0]) ||
                 (size_l[1] && (addr_l[1:0] != 2'b00));
`else
  assign fault = 1'b0;
`endif

  // Next state. DONE is released only after moc has been visible for at
  // least one cycle, so an early mov drop still yields one moc pulse.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    exec      = 1'b0;
    leave     = 1'b0;
    case (state)
      IDLE: begin
        if (enable && mov) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          exec      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (moc && !mov) begin
          leave     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      moc      <= 1'b0;
      data_out <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= WAIT_INIT;
      else if ((state == BUSY) && (cnt != 4'd0))
        cnt <= cnt - 4'd1;
      if (leave)
        moc <= 1'b0;
      else if (state == DONE)
        moc <= 1'b1;
      if (exec && rw_l && !fault)
        data_out <= load_extract(word_rd, size_l, addr_l[1:0], uns_l);
    end
  end

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err <= 1'b0;
    else if (exec)
      err <= fault;
    else if (leave)
      err <= 1'b0;
  end
`else
  assign err = 1'b0;
`endif

  // Request latch: later input changes are ignored until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_l   <= rw;
      uns_l  <= unsigned_ld;
      size_l <= size;
      addr_l <= addr[AW+1:0];
      din_l  <= data_in;
    end
  end

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (exec && !rw_l && !fault)
      mem[widx] <= store_merge(word_rd, din_l, size_l, addr_l[1:0]);
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized and directed bench for data_mem_ctrl.
// A byte-array reference model predicts load data and fault status.
module tb_data_mem_ctrl;

  localparam int DEPTH = 128;
  localparam int WAIT  = 2;
  localparam int SPAN  = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mov;
  logic        rw;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        moc;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mbytes [SPAN];
  logic [31:0] exp_dout;

  data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mov(mov), .rw(rw),
    .size(size), .unsigned_ld(unsigned_ld), .addr(addr), .data_in(data_in),
    .data_out(data_out), .moc(moc), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-level reference: big-endian, addresses modulo SPAN.
  task automatic model_op(input logic rw_i, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d, output logic e);
    int off, n, base;
    logic [31:0] v;
    off = int'(a % 32'(SPAN));
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    e = 1'b0;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    if ((off % n) != 0) e = 1'b1;
`endif
    if (!e) begin
      base = off - (off % n);
      if (!rw_i) begin
        for (int i = 0; i < n; i++)
          mbytes[base + i] = 8'(d >> (8 * (n - 1 - i)));
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++)
          v = (v << 8) | 32'(mbytes[base + i]);
        if (!uns && n < 4 && v[8 * n - 1])
          v = v | (32'hFFFF_FFFF << (8 * n));
        exp_dout = v;
      end
    end
  endtask

  // One full handshake. drop = release mov during BUSY; otherwise mov is
  // held for 'hold' extra cycles after moc before release.
  task automatic access(input logic rw_i, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit drop, input int hold, output logic [31:0] obs);
    logic e;
    model_op(rw_i, sz, uns, a, d, e);
    enable = 1'b1; mov = 1'b1; rw = rw_i; size = sz; unsigned_ld = uns;
    addr = a; data_in = d;
    @(posedge clk); #1;
    chk_val("busy_start", busy, 1);
    addr = $urandom; data_in = $urandom; rw = 1'($urandom);
    size = 2'($urandom); unsigned_ld = 1'($urandom); enable = 1'($urandom);
    if (drop) mov = 1'b0;
    repeat (WAIT + 1) @(posedge clk);
    #1;
    chk_val("moc_early", moc, 0);
    @(posedge clk); #1;
    chk_val("moc_rise", moc, 1);
    chk_val("busy_done", busy, 1);
    chk_val("err", err, e);
    chk_val("dout", data_out, exp_dout);
    obs = data_out;
    if (!drop) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk_val("moc_hold", moc, 1);
        chk_val("dout_hold", data_out, exp_dout);
      end
      mov = 1'b0;
    end
    @(posedge clk); #1;
    chk_val("moc_fall", moc, 0);
    chk_val("busy_end", busy, 0);
    chk_val("err_end", err, 0);
  endtask

  initial begin
    logic [31:0] obs;
    logic [31:0] ra;
    reset = 1'b0; enable = 1'b0; mov = 1'b0; rw = 1'b0; size = 2'b00;
    unsigned_ld = 1'b0; addr = 32'h0; data_in = 32'h0;
    exp_dout = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_moc", moc, 0);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_err", err, 0);
    chk_val("rst_dout", data_out, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Known contents for word indices 0..15.
    for (int w = 0; w < 16; w++)
      access(1'b0, 2'b10, 1'b0, 32'(w * 4), $urandom, 1'b0, 0, obs);

    // Enable low: request is ignored.
    enable = 1'b0; mov = 1'b1;
    @(posedge clk); #1;
    chk_val("en_low_busy", busy, 0);
    mov = 1'b0;
    @(posedge clk); #1;

    // Word store/load.
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 0, obs);
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 0, obs);
    chk_val("tp_word", obs, 32'hDEADBEEF);

    // Byte store and byte loads.
    access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0000005A, 1'b0, 0, obs);
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 0, obs);
    chk_val("tp_byte_merge", obs, 32'hDE5ABEEF);
    access(1'b1, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0, 0, obs);
    chk_val("tp_byte_s", obs, 32'hFFFFFFBE);
    access(1'b1, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0, 0, obs);
    chk_val("tp_byte_u", obs, 32'h000000BE);

    // Halfword sign extension and address wrap.
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h12348001, 1'b0, 0, obs);
    access(1'b1, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 0, obs);
    chk_val("tp_half_s", obs, 32'hFFFF8001);
    access(1'b1, 2'b10, 1'b0, 32'h10 + 32'(SPAN), 32'h0, 1'b0, 0, obs);
    chk_val("tp_wrap", obs, 32'h12348001);

    // mov dropped in BUSY, then mov held high after moc.
    access(1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1, 0, obs);
    access(1'b1, 2'b00, 1'b1, 32'h7, 32'h0, 1'b0, 5, obs);

    // Reset during a BUSY store.
    enable = 1'b1; mov = 1'b1; rw = 1'b0; size = 2'b10; addr = 32'h10;
    data_in = 32'h0BADF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk_val("rstb_moc", moc, 0);
    chk_val("rstb_busy", busy, 0);
    chk_val("rstb_dout", data_out, 32'h0);
    mov = 1'b0;
    #2;
    reset = 1'b1;
    exp_dout = 32'h0;
    @(posedge clk); #1;
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 0, obs);
    chk_val("rstb_word", obs, 32'h12348001);

    // Misaligned word store.
    access(1'b0, 2'b10, 1'b0, 32'h13, 32'hCAFEF00D, 1'b0, 1, obs);
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 0, obs);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    chk_val("mis_word", obs, 32'h12348001);
`else
    chk_val("mis_word", obs, 32'hCAFEF00D);
`endif

    // Randomized traffic.
    for (int k = 0; k < 60; k++) begin
      ra = ($urandom & ~32'(SPAN - 1)) | 32'($urandom_range(0, 63));
      access(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom,
             1'($urandom), int'($urandom_range(0, 3)), obs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Data-memory stage directly downstream of the CPU datapath: consumes the ALU address, the register-B store data and the memory control signals; produces load data for the write-back mux.
- Implements the MOV/MOC handshake: CPU raises mov; block raises moc when the access is complete.
- Contains a word-organised, byte-addressed, big-endian RAM array with byte/halfword/word access, sign/zero extension and programmable wait states.

Parameters:
- DEPTH, 128, number of 32-bit words in the array; must be a power of 2.
- WAIT_CYCLES, 2, extra cycles spent in BUSY before the access executes; legal range 0..15.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  chip enable; a request is accepted only when high.
- mov  in  1  memory operation valid, driven by the CPU.
- rw  in  1  1 = read (load), 0 = write (store).
- size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- unsigned_ld  in  1  1 = zero-extend byte/half loads; 0 = sign-extend.
- addr  in  32  byte address (ALU result).
- data_in  in  32  store data; byte/half taken from the low bits.
- data_out  out  32  registered load data.
- moc  out  1  memory operation complete.
- busy  out  1  high in BUSY and DONE.
- err  out  1  access fault; valid while moc = 1; only with the optional feature.

Behaviour:
- Reset (reset = 0, asynchronous):
  - FSM goes to IDLE.
  - moc = 0, busy = 0, err = 0, data_out = 32'h0, wait counter = 0.
  - Array contents are not cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On a clk edge with enable & mov = 1, latch addr, data_in, rw, size and unsigned_ld.
  - Load the counter with WAIT_CYCLES and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Counter decrements each cycle.
  - On the cycle the counter is 0, the access executes: array write, or data_out update for a read.
  - FSM then goes to DONE.
  - With WAIT_CYCLES = 0, BUSY lasts exactly one cycle.
- DONE:
  - moc = 1.
  - Return to IDLE on the first edge where mov = 0; moc drops in the same edge.
- Latency: mov sampled high at edge N → moc high after edge N+WAIT_CYCLES+2.
- Input changes during BUSY/DONE are ignored; only latched values are used.
- mov dropped during BUSY: the access still completes, and moc is high for exactly one cycle in DONE.
- mov still high after moc: the block stays in DONE; no second access starts until mov has been low for at least one edge.
- Word index = addr[log2(DEPTH)+1:2]; higher bits are ignored, so addresses wrap modulo 4*DEPTH.
- Big-endian byte lanes: addr[1:0] = 0 selects bits 31:24; 3 selects bits 7:0. Halfword at addr[1] = 0 selects bits 31:16.
- Stores modify only the addressed lanes; other bytes are preserved.
- Loads right-justify the selected lane, then sign- or zero-extend per the latched unsigned_ld.
- Writes leave data_out unchanged.
- Without the optional feature:
  - Misaligned addresses are force-aligned: addr[0] cleared for half; addr[1:0] cleared for word.
  - err is held at 0.

Optional Feature:
- Macro: DATA_MEM_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0] = 1, or a word with addr[1:0] != 0, is a fault:
  - No array write occurs and data_out is unchanged.
  - err = 1 for the whole DONE state; cleared on return to IDLE.
  - Handshake timing is identical to a normal access.
- Undefined: force-alignment as above; the err port still exists, tied to 0.

Test Plan:
- Reset, then word store addr 0x10, data 0xDEADBEEF, WAIT_CYCLES = 2 → moc rises after the 4th edge after mov; then a word load at 0x10 → data_out = 0xDEADBEEF.
- Byte store 0x5A to addr 0x11 over word 0xDEADBEEF → word reads 0xDE5ABEEF; byte load at 0x12 with unsigned_ld = 0 → 0xFFFFFFBE; with unsigned_ld = 1 → 0x000000BE.
- Halfword load at 0x12 of word 0x12348001, signed → 0xFFFF8001; addr 0x10 + 4*DEPTH → same word as 0x10 (wrap).
- mov dropped during BUSY → exactly one cycle of moc; mov held high 5 cycles after moc → moc stays high, no new access until mov goes low and then high again.
- Assert reset while in BUSY on a store → moc = 0, data_out = 0, FSM in IDLE; the target word is unchanged and the next access works normally.
- With DATA_MEM_MISALIGN_TRAP_EN, word store at 0x13 → err = 1 with moc and memory unchanged; without it → the store lands at 0x10.
